// File: rtl/cap_sense_scanner_if.sv
// Processor-facing side of the touch scanner: debounced touch map,
// sticky press events with ack/mask clearing, and per-pad count readback.
interface cap_sense_scanner_if #(
  parameter int NUM_SENSORS = 9,
  parameter int CNT_W       = 12
);
  logic [3:0]             sel;
  logic                   ack;
  logic [NUM_SENSORS-1:0] ack_mask;
  logic [NUM_SENSORS-1:0] touch_map;
  logic [NUM_SENSORS-1:0] press_event;
  logic                   event_valid;
  logic                   scan_done;
  logic [CNT_W-1:0]       count_out;

  modport master (
    output sel, ack, ack_mask,
    input  touch_map, press_event, event_valid, scan_done, count_out
  );

  modport slave (
    input  sel, ack, ack_mask,
    output touch_map, press_event, event_valid, scan_done, count_out
  );
endinterface

// File: rtl/cap_sense_scanner.sv
// Capacitive pad scanner: charge all pads, time each discharge, threshold,
// debounce into a touch map and raise sticky press events.
module cap_sense_scanner #(
  parameter int NUM_SENSORS    = 9,
  parameter int CHARGE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 12,
  parameter int THRESHOLD      = 200,
  parameter int DEBOUNCE       = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  cap_sense_scanner_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, EVAL} state_t;

  localparam int CH_W = $clog2(CHARGE_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [CH_W-1:0]  CHARGE_LAST  = CH_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] THRESH       = CNT_W'(THRESHOLD);
  localparam logic [DB_W-1:0]  DB_TARGET    = DB_W'(DEBOUNCE);

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        charge_cnt_q, charge_cnt_d;
  logic [CNT_W-1:0]       m_q, m_d;
  logic [NUM_SENSORS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_SENSORS-1:0] fallen_q, fallen_d, new_fall;
  logic [NUM_SENSORS-1:0] touch_map_q, touch_map_d;
  logic [NUM_SENSORS-1:0] press_event_q, press_event_d;
  logic [CNT_W-1:0]       count_q [NUM_SENSORS];
  logic [CNT_W-1:0]       count_d [NUM_SENSORS];
  logic [CNT_W-1:0]       shown_q [NUM_SENSORS];
  logic [CNT_W-1:0]       shown_d [NUM_SENSORS];
  logic [DB_W-1:0]        agree_q [NUM_SENSORS];
  logic [DB_W-1:0]        agree_d [NUM_SENSORS];
  logic [DB_W-1:0]        agree_inc;
  logic                   out_q, out_d;
  logic                   scan_done_q, scan_done_d;
  logic [CNT_W-1:0]       count_out_q, count_out_d;

  always_comb begin
    state_d      = state_q;
    charge_cnt_d = charge_cnt_q;
    m_d          = m_q;
    fallen_d     = fallen_q;
    touch_map_d  = touch_map_q;
    count_d      = count_q;
    shown_d      = shown_q;
    agree_d      = agree_q;
    new_fall     = '0;
    agree_inc    = '0;
    sync1_d      = capacitive_sensors_in;
    sync2_d      = sync1_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d      = CHARGE;
          charge_cnt_d = '0;
          m_d          = '0;
          fallen_d     = '0;
        end
      end
      CHARGE: begin
        if (charge_cnt_q == CHARGE_LAST) begin
          state_d = MEASURE;
        end else begin
          charge_cnt_d = charge_cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        new_fall = ~fallen_q & ~sync2_q;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (new_fall[i]) count_d[i] = m_q;
        end
        fallen_d = fallen_q | new_fall;
        if (&fallen_d) begin
          state_d = EVAL;
        end else if (m_q == TIMEOUT_LAST) begin
          state_d = EVAL;
          for (int i = 0; i < NUM_SENSORS; i++) begin
            if (!fallen_d[i]) count_d[i] = TIMEOUT_CNT;
          end
        end else begin
          m_d = m_q + 1'b1;
        end
      end
      EVAL: begin
        // A pad's counter only survives consecutive scans that disagree with touch_map.
        for (int i = 0; i < NUM_SENSORS; i++) begin
          shown_d[i] = count_q[i];
          if ((count_q[i] >= THRESH) != touch_map_q[i]) begin
            agree_inc = agree_q[i] + 1'b1;
            if (agree_inc == DB_TARGET) begin
              touch_map_d[i] = ~touch_map_q[i];
              agree_d[i]     = '0;
            end else begin
              agree_d[i] = agree_inc;
            end
          end else begin
            agree_d[i] = '0;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    press_event_d = (press_event_q & ~(bus.ack ? bus.ack_mask : '0))
                  | (touch_map_d & ~touch_map_q);
    out_d         = (state_d == CHARGE);
    scan_done_d   = (state_d == EVAL);

    count_out_d = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (int'(bus.sel) == i) count_out_d = shown_d[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      charge_cnt_q  <= '0;
      m_q           <= '0;
      sync1_q       <= '1;
      sync2_q       <= '1;
      fallen_q      <= '0;
      touch_map_q   <= '0;
      press_event_q <= '0;
      count_q       <= '{default: '0};
      shown_q       <= '{default: '0};
      agree_q       <= '{default: '0};
      out_q         <= 1'b0;
      scan_done_q   <= 1'b0;
      count_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      charge_cnt_q  <= charge_cnt_d;
      m_q           <= m_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      fallen_q      <= fallen_d;
      touch_map_q   <= touch_map_d;
      press_event_q <= press_event_d;
      count_q       <= count_d;
      shown_q       <= shown_d;
      agree_q       <= agree_d;
      out_q         <= out_d;
      scan_done_q   <= scan_done_d;
      count_out_q   <= count_out_d;
    end
  end

  assign capacitive_sensors_out = out_q;
  assign bus.touch_map          = touch_map_q;
  assign bus.press_event        = press_event_q;
  assign bus.event_valid        = |press_event_q;
  assign bus.scan_done          = scan_done_q;
  assign bus.count_out          = count_out_q;

endmodule
